// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, try subtracting the divisor,
// keep the difference and set the new quotient bit only when it did not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_trial;

    // One extra bit on top of the 33-bit remainder gives a clean borrow/sign bit
    assign w_trial = {i_rem, i_quo[WIDTH-1]} - {2'b00, i_divisor};

    always_comb begin
        o_rem = w_trial[WIDTH:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b1};
        if (w_trial[WIDTH+1]) begin
            o_rem = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div.sv
// Multi-cycle signed divider for the MIPS datapath: lo = quotient, hi = remainder.
// Shares the start/end handshake and falling-edge timing of the Booth multiplier.
module div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_end,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_signQ;
    logic             r_signR;
    logic             r_zero;

    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;
    logic [WIDTH:0]   w_nextRem;
    logic [WIDTH-1:0] w_nextQuo;

    // Unsigned magnitudes; the most negative value maps onto itself, which is still correct unsigned
    assign w_magA = A[WIDTH-1] ? -A : A;
    assign w_magB = B[WIDTH-1] ? -B : B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_nextRem),
        .o_quo     (w_nextQuo)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
            r_zero    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_end   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (div_start) begin
                        r_divisor <= w_magB;
                        r_signQ   <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_signR   <= A[WIDTH-1];
                        r_rem     <= '0;
                        r_quo     <= w_magA;
                        r_count   <= '0;
                        r_zero    <= (B == '0);
                        div_end   <= 1'b0;
                        div_zero  <= 1'b0;
                        // A zero divisor skips the iterations and is flagged in FIX
                        r_state   <= (B == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    r_rem   <= w_nextRem;
                    r_quo   <= w_nextQuo;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        div_zero <= 1'b1;
                    end else begin
                        lo <= r_signQ ? -r_quo : r_quo;
                        hi <= r_signR ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    end
                    div_end <= 1'b1;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized operands
// checked against a 64-bit arithmetic reference of truncating signed division.
module tb_div;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_end;
    logic        div_zero;

    int testCount;
    int failCount;

    div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_start (div_start),
        .A         (A),
        .B         (B),
        .hi        (hi),
        .lo        (lo),
        .div_end   (div_end),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: truncating signed division done in 64 bits so the overflow case cannot trap
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa - lq * sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Drives one start pulse; returns right after the accepting falling edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        A = a;
        B = b;
        div_start = 1'b1;
        @(posedge clk);
        div_start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        testCount++;
        if ({hi, lo, div_end, div_zero} !== 66'd0) begin
            failCount++;
            $display("[TB] FAIL reset: got hi=%h lo=%h end=%b zero=%b, expected all zero",
                     hi, lo, div_end, div_zero);
        end
        @(posedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [31:0] tq [5];
        logic [31:0] tr [5];
        ta = '{32'd100, 32'hFFFFFF9C, 32'd100,      32'h80000000, 32'h80000000};
        tb = '{32'd7,   32'd7,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1};
        tq = '{32'd14,  32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000, 32'h80000000};
        tr = '{32'd2,   32'hFFFFFFFE, 32'd2,        32'd0,        32'd0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ta[i], tb[i]);
            repeat (32) @(posedge clk);
            testCount++;
            if (div_end !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL directed latency %0d: div_end=%b after 33 edges, expected 0", i, div_end);
            end
            @(posedge clk);
            testCount++;
            if ({div_end, div_zero, lo, hi} !== {1'b1, 1'b0, tq[i], tr[i]}) begin
                failCount++;
                $display("[TB] FAIL directed %0d: got end=%b zero=%b lo=%h hi=%h, expected end=1 zero=0 lo=%h hi=%h",
                         i, div_end, div_zero, lo, hi, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        for (int i = 0; i < 20; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == 32'd0) b = 32'd3;
            model(a, b, q, r);
            applyStimulus(a, b);
            repeat (33) @(posedge clk);
            testCount++;
            if ({div_end, div_zero, lo, hi} !== {1'b1, 1'b0, q, r}) begin
                failCount++;
                $display("[TB] FAIL random %h/%h: got end=%b zero=%b lo=%h hi=%h, expected lo=%h hi=%h",
                         a, b, div_end, div_zero, lo, hi, q, r);
            end
        end
    endtask

    task automatic test_div_zero();
        applyStimulus(32'd100, 32'd7);
        repeat (33) @(posedge clk);
        applyStimulus(32'd5, 32'd0);
        testCount++;
        if ({div_end, div_zero} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL zero accept: got end=%b zero=%b, expected 0 0", div_end, div_zero);
        end
        @(posedge clk);
        testCount++;
        if ({div_end, div_zero, lo, hi} !== {1'b1, 1'b1, 32'd14, 32'd2}) begin
            failCount++;
            $display("[TB] FAIL zero result: got end=%b zero=%b lo=%h hi=%h, expected end=1 zero=1 lo=0000000e hi=00000002",
                     div_end, div_zero, lo, hi);
        end
        repeat (3) @(posedge clk);
        testCount++;
        if ({div_end, div_zero, lo, hi} !== {1'b1, 1'b1, 32'd14, 32'd2}) begin
            failCount++;
            $display("[TB] FAIL zero hold: got end=%b zero=%b lo=%h hi=%h, expected held values",
                     div_end, div_zero, lo, hi);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        rst = 1'b1;
        #1;
        testCount++;
        if ({hi, lo, div_end, div_zero} !== 66'd0) begin
            failCount++;
            $display("[TB] FAIL mid reset: got hi=%h lo=%h end=%b zero=%b, expected all zero",
                     hi, lo, div_end, div_zero);
        end
        @(posedge clk);
        rst = 1'b0;
        applyStimulus(32'd9, 32'd3);
        repeat (33) @(posedge clk);
        testCount++;
        if ({div_end, lo, hi} !== {1'b1, 32'd3, 32'd0}) begin
            failCount++;
            $display("[TB] FAIL after reset: got end=%b lo=%h hi=%h, expected end=1 lo=00000003 hi=00000000",
                     div_end, lo, hi);
        end
    endtask

    task automatic test_ignore_restart();
        applyStimulus(32'd100, 32'd7);
        repeat (4) @(posedge clk);
        A = 32'd1;
        B = 32'd1;
        div_start = 1'b1;
        @(posedge clk);
        div_start = 1'b0;
        repeat (27) @(posedge clk);
        testCount++;
        if (div_end !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL restart latency: div_end=%b, expected 0", div_end);
        end
        @(posedge clk);
        testCount++;
        if ({div_end, lo, hi} !== {1'b1, 32'd14, 32'd2}) begin
            failCount++;
            $display("[TB] FAIL restart ignored: got end=%b lo=%h hi=%h, expected end=1 lo=0000000e hi=00000002",
                     div_end, lo, hi);
        end
        applyStimulus(32'd9, 32'd3);
        testCount++;
        if (div_end !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL done accept: div_end=%b, expected 0", div_end);
        end
        repeat (33) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa [3];
        logic [31:0] ob [3];
        logic [31:0] q;
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            oa[i] = $urandom;
            ob[i] = $urandom >> $urandom_range(0, 28);
            if (ob[i] == 32'd0) ob[i] = 32'd5;
        end
        @(posedge clk);
        A = oa[0];
        B = ob[0];
        div_start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                A = oa[i+1];
                B = ob[i+1];
            end else begin
                div_start = 1'b0;
            end
            repeat (33) @(posedge clk);
            model(oa[i], ob[i], q, r);
            testCount++;
            if ({div_end, lo, hi} !== {1'b1, q, r}) begin
                failCount++;
                $display("[TB] FAIL back-to-back %0d: got end=%b lo=%h hi=%h, expected end=1 lo=%h hi=%h",
                         i, div_end, lo, hi, q, r);
            end
            if (i < 2) begin
                @(posedge clk);
                testCount++;
                if (div_end !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL back-to-back drop %0d: div_end=%b, expected 0", i, div_end);
                end
            end
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        div_start = 1'b0;
        A         = '0;
        B         = '0;
        test_reset();
        test_directed();
        test_random();
        test_div_zero();
        test_reset_mid();
        test_ignore_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
